// File: rtl/uart_fifo_ext.sv
// rtl/uart_fifo_ext.sv - parametrised FWFT FIFO with level, trigger and sticky error flags
//
// Purpose: byte/word FIFO for the UART TX and RX datapaths. The head entry is
// presented combinationally on rdata (first-word-fall-through).
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   wdata     in   WIDTH   write data
//   push      in   write request (dropped when full, sets overrun)
//   pop       in   read request, consumes rdata (ignored when empty, sets underrun)
//   flush     in   synchronous clear of pointers; dominates push/pop
//   thresh    in   AW+1    trigger level 0..2^AW
//   err_clr   in   clears overrun/underrun; a same-cycle error event wins
//   rdata     out  WIDTH   head entry
//   empty     out  no entries
//   full      out  2^AW entries
//   level     out  AW+1    occupancy 0..2^AW
//   trig      out  level >= thresh
//   overrun   out  sticky, push attempted while full
//   underrun  out  sticky, pop attempted while empty

module uart_fifo_ext #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [AW:0]      thresh,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level,
  output logic             trig,
  output logic             overrun,
  output logic             underrun
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wp_q, wp_d;
  logic [AW:0]      rp_q, rp_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;

  logic             push_ok;
  logic             pop_ok;
  logic             push_err;
  logic             pop_err;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign level = wp_q - rp_q;

  // thresh == 0 is always satisfied; thresh above DEPTH can never be reached.
  assign trig  = (level >= thresh);

  assign rdata    = mem_q[rp_q[AW-1:0]];
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

  // Flush suppresses both the transfers and the error events they would cause.
  assign push_ok  = push & ~full  & ~flush;
  assign pop_ok   = pop  & ~empty & ~flush;
  assign push_err = push &  full  & ~flush;
  assign pop_err  = pop  &  empty & ~flush;

  always_comb begin
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wp_q[AW-1:0]] = wdata;
        wp_d = wp_q + 1'b1;
      end
      if (pop_ok) begin
        rp_d = rp_q + 1'b1;
      end
    end

    // Clear first so a same-cycle error event overrides it.
    if (err_clr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (push_err) overrun_d  = 1'b1;
    if (pop_err)  underrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q       <= '0;
      rp_q       <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
